sel_skid_mux: RTL and testbench
===============================

# sel_skid_mux

Parametrised N-input select stage with a registered two-entry skid buffer and valid/ready handshake. It replaces fixed-width combinational 2:1 and 4:1 selects wherever a pipeline stage must pick one of several operands and register the result under backpressure, such as operand forwarding or writeback select. The result is registered, and `in_ready` has no combinational path from `out_ready`.

## Interface
- `WIDTH`, default `` `WORD_SIZE `` (16): data width per input.
- `NUM_IN`, default 4: number of selectable inputs; legal range is 2..16.
- `SEL_W`, default 2: select width; requires 2^SEL_W >= NUM_IN.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  NUM_IN*WIDTH  flattened inputs; input i is `in_data[i*WIDTH +: WIDTH]`.
- `in_sel`  in  SEL_W  input index, sampled when a beat is accepted.
- `in_valid`  in  1  producer has a beat.
- `in_ready`  out  1  block can accept a beat.
- `out_data`  out  WIDTH  selected data of the head entry.
- `out_sel`  out  SEL_W  `in_sel` captured with the head entry.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer takes the head entry.
- `flush`  in  1  synchronous discard of all entries.
- `count`  out  2  occupancy, 0..2.
- `err`  out  1  sticky out-of-range-select flag (see Configuration).

## Operation
- Storage is a main register (head) plus a skid register, each holding data and sel.
- States, encoded in `count`:
  - EMPTY = 0
  - ONE = 1
  - FULL = 2
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- On push, the block captures the selected input `in_data[in_sel*WIDTH +: WIDTH]` together with `in_sel`.
- State transitions:
  - EMPTY: push → ONE (main loads).
  - ONE, push and no pop → FULL (skid loads).
  - ONE, push and pop → ONE (main reloads with the new beat).
  - ONE, pop and no push → EMPTY.
  - FULL: pop → ONE (main <= skid). Push cannot occur in FULL.
- Output decode:
  - `in_ready` = (state != FULL); it is a function of registered state only.
  - `out_valid` = (state != EMPTY).
  - `out_data`/`out_sel` always reflect the main register.
- Ordering is strictly FIFO. Beats are never duplicated or dropped except by `flush` or `reset`.
- Flush:
  - Forces EMPTY next cycle.
  - Overrides any simultaneous push or pop; a beat offered in the flush cycle is discarded.
  - Data registers keep stale contents; `out_valid` = 0 masks them.
- Reset:
  - Overrides flush.
  - Clears state to EMPTY, clears all data/sel registers and `err`.
  - Inputs during reset cycles are ignored.

## Timing
- Values after reset:
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `count`=0, `err`=0.
  - `in_ready`=1 from the first cycle after reset; during reset cycles the state is already EMPTY, so `in_ready` reads 1 but pushes are discarded.
- Latency: a beat pushed at edge k appears on `out_data` with `out_valid`=1 after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Backpressure: with `out_ready` low, two beats are absorbed. `in_ready` falls the cycle after the second push.
- Handshake rules:
  - Producer must hold `in_data`/`in_sel` stable while `in_valid` is high and `in_ready` is low.
  - `out_*` are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- Macro: `SEL_SKID_MUX_RANGE_CHECK_EN`.
- With the macro defined, a push with `in_sel` >= NUM_IN:
  - stores data 0, with `out_sel` = the raw select;
  - sets `err`=1 the cycle after the push;
  - `err` stays set through flush and clears only on `reset`.
- Without the macro:
  - an out-of-range select captures input NUM_IN-1 (same as the last-input default of the fixed 4:1 select);
  - `err` is tied to 0.

## Test plan
1. **Reset:** assert `reset` 2 cycles with `in_valid`=1 → after release, `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1, `err`=0, and nothing was captured.
2. **Streaming** (WIDTH=16, NUM_IN=4): inputs are 0x1111/0x2222/0x3333/0x4444. Push sel 0,1,2,3 on consecutive cycles with `out_ready`=1 → `out_data` = 0x1111, 0x2222, 0x3333, 0x4444 on the following 4 cycles, no bubbles, `count`=1 throughout.
3. **Backpressure:** with `out_ready`=0, push sel 2 then sel 3, and hold `in_valid` with sel 0 → `count`=2, `in_ready`=0, third beat not taken. Raise `out_ready` → outputs 0x3333, 0x4444, then 0x1111.
4. **Flush:** at `count`=2, assert `flush` with `in_valid`=1 and `out_ready`=1 → next cycle `count`=0, `out_valid`=0, `in_ready`=1, and the offered beat never appears.
5. **Simultaneous push/pop in ONE:** head holds 0x1111; push sel 3 while popping → `count` stays 1 and `out_data`=0x4444 next cycle.
6. **Out-of-range select** (NUM_IN=3, SEL_W=2): push sel=3.
   - With the macro: `out_data`=0, `out_sel`=3, `err`=1; `err` holds through flush and clears after reset.
   - Without the macro: `out_data` = input 2, `err`=0.

Source files
------------

// File: rtl/sel_skid_mux.sv
// sel_skid_mux: N-input select stage with a registered two-entry skid buffer.
// The head (main) register drives out_data/out_sel. The skid register absorbs
// the one extra beat that can arrive while the consumer stalls. in_ready
// depends only on registered state, so it has no path from out_ready.
// Optional feature macro: SEL_SKID_MUX_RANGE_CHECK_EN. When defined, an
// out-of-range select stores 0 and raises a sticky err. When undefined, an
// out-of-range select picks input NUM_IN-1 and err is tied low.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module sel_skid_mux #(
    parameter int WIDTH  = `WORD_SIZE,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic [1:0]              count,
    output logic                    err
);

    // Handshake: a beat moves on a cycle where valid && ready are both high at
    // the rising edge. The producer holds in_data/in_sel while in_valid=1 and
    // in_ready=0. out_* stay stable while out_valid=1 and out_ready=0.

    // The state encoding doubles as the occupancy seen on count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   main_data_q;
    logic [WIDTH-1:0]   skid_data_q;
    logic [SEL_W-1:0]   main_sel_q;
    logic [SEL_W-1:0]   skid_sel_q;
    logic [WIDTH-1:0]   pick_data;
    logic               push;
    logic               pop;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign count     = state_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef SEL_SKID_MUX_RANGE_CHECK_EN
    // NUM_IN widened by one bit so that NUM_IN == 2**SEL_W is representable.
    localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];
    logic in_range;
    assign in_range = ({1'b0, in_sel} < NUM_IN_W);
`endif

    // Select the operand named by in_sel; unmatched selects keep the default.
    always_comb begin
`ifdef SEL_SKID_MUX_RANGE_CHECK_EN
        pick_data = '0;
`else
        pick_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
`endif
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                pick_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and register-load decode; flush discards everything in flight.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head and skid storage; stale contents are left in place on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            if (load_main_in) begin
                main_data_q <= pick_data;
                main_sel_q  <= in_sel;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_sel_q  <= skid_sel_q;
            end
            if (load_skid) begin
                skid_data_q <= pick_data;
                skid_sel_q  <= in_sel;
            end
        end
    end

`ifdef SEL_SKID_MUX_RANGE_CHECK_EN
    logic err_q;

    // Sticky error: set by any accepted out-of-range beat, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((load_main_in || load_skid) && !in_range) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_skid_mux.sv
// Testbench for sel_skid_mux: a directed vector table on a 4-input instance,
// an in-order scoreboard run under an irregular out_ready pattern, and a
// hand sequence on a 3-input instance for the out-of-range select.

module tb_sel_skid_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-input instance
    logic [63:0] a_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic        a_rst  = 1'b1;
    logic        a_fl   = 1'b0;
    logic        a_iv   = 1'b0;
    logic [1:0]  a_sel  = 2'd0;
    logic        a_ordy = 1'b0;
    logic        a_ir, a_ov, a_err;
    logic [15:0] a_od;
    logic [1:0]  a_os, a_cnt;

    sel_skid_mux #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut_a (
        .clk(clk), .reset(a_rst), .in_data(a_data), .in_sel(a_sel),
        .in_valid(a_iv), .in_ready(a_ir), .out_data(a_od), .out_sel(a_os),
        .out_valid(a_ov), .out_ready(a_ordy), .flush(a_fl), .count(a_cnt),
        .err(a_err)
    );

    // 3-input instance for out-of-range selects
    logic [47:0] b_data = {16'hcccc, 16'hbbbb, 16'haaaa};
    logic        b_rst  = 1'b1;
    logic        b_fl   = 1'b0;
    logic        b_iv   = 1'b0;
    logic [1:0]  b_sel  = 2'd0;
    logic        b_ordy = 1'b0;
    logic        b_ir, b_ov, b_err;
    logic [15:0] b_od;
    logic [1:0]  b_os, b_cnt;

    sel_skid_mux #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut_b (
        .clk(clk), .reset(b_rst), .in_data(b_data), .in_sel(b_sel),
        .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od), .out_sel(b_os),
        .out_valid(b_ov), .out_ready(b_ordy), .flush(b_fl), .count(b_cnt),
        .err(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One cycle on instance A: drive at negedge, sample 1 time unit after posedge.
    task automatic step_a(input logic rst, input logic fl, input logic iv,
                          input logic [1:0] sel, input logic ordy);
        @(negedge clk);
        a_rst = rst; a_fl = fl; a_iv = iv; a_sel = sel; a_ordy = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic fl, input logic iv,
                          input logic [1:0] sel, input logic ordy);
        @(negedge clk);
        b_rst = rst; b_fl = fl; b_iv = iv; b_sel = sel; b_ordy = ordy;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, fl, iv;
        logic [1:0]  sel;
        logic        ordy;
        logic [1:0]  cnt;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  os;
        logic        ir;
        logic        chk_d;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [1:0] sel, input logic ordy,
                                input logic [1:0] cnt, input logic ov,
                                input logic [15:0] od, input logic [1:0] os,
                                input logic ir, input logic chk_d);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.sel = sel; v.ordy = ordy;
        v.cnt = cnt; v.ov = ov; v.od = od; v.os = os; v.ir = ir; v.chk_d = chk_d;
        return v;
    endfunction

    localparam int NV = 27;
    vec_t vecs[NV];

    logic [15:0] exp_q[$];

    function automatic logic [15:0] a_val(input logic [1:0] s);
        case (s)
            2'd0: return 16'h1111;
            2'd1: return 16'h2222;
            2'd2: return 16'h3333;
            default: return 16'h4444;
        endcase
    endfunction

    initial begin
        // Inputs applied before an edge; expected outputs just after that edge.
        //               rst fl iv sel ordy  cnt ov  od        os  ir chk_d
        // reset held two cycles with a beat offered
        vecs[0]  = mk(1, 0, 1, 2'd1, 0,   2'd0, 0, 16'h0000, 2'd0, 1, 1);
        vecs[1]  = mk(1, 0, 1, 2'd1, 0,   2'd0, 0, 16'h0000, 2'd0, 1, 1);
        vecs[2]  = mk(0, 0, 0, 2'd0, 0,   2'd0, 0, 16'h0000, 2'd0, 1, 1);
        // streaming sel 0..3, no bubbles
        vecs[3]  = mk(0, 0, 1, 2'd0, 1,   2'd1, 1, 16'h1111, 2'd0, 1, 1);
        vecs[4]  = mk(0, 0, 1, 2'd1, 1,   2'd1, 1, 16'h2222, 2'd1, 1, 1);
        vecs[5]  = mk(0, 0, 1, 2'd2, 1,   2'd1, 1, 16'h3333, 2'd2, 1, 1);
        vecs[6]  = mk(0, 0, 1, 2'd3, 1,   2'd1, 1, 16'h4444, 2'd3, 1, 1);
        vecs[7]  = mk(0, 0, 0, 2'd0, 1,   2'd0, 0, 16'h0000, 2'd0, 1, 0);
        // backpressure: two absorbed, third held off
        vecs[8]  = mk(0, 0, 1, 2'd2, 0,   2'd1, 1, 16'h3333, 2'd2, 1, 1);
        vecs[9]  = mk(0, 0, 1, 2'd3, 0,   2'd2, 1, 16'h3333, 2'd2, 0, 1);
        vecs[10] = mk(0, 0, 1, 2'd0, 0,   2'd2, 1, 16'h3333, 2'd2, 0, 1);
        vecs[11] = mk(0, 0, 1, 2'd0, 1,   2'd1, 1, 16'h4444, 2'd3, 1, 1);
        vecs[12] = mk(0, 0, 1, 2'd0, 1,   2'd1, 1, 16'h1111, 2'd0, 1, 1);
        vecs[13] = mk(0, 0, 0, 2'd0, 1,   2'd0, 0, 16'h0000, 2'd0, 1, 0);
        // flush at count 2 with a beat offered and out_ready high
        vecs[14] = mk(0, 0, 1, 2'd1, 0,   2'd1, 1, 16'h2222, 2'd1, 1, 1);
        vecs[15] = mk(0, 0, 1, 2'd2, 0,   2'd2, 1, 16'h2222, 2'd1, 0, 1);
        vecs[16] = mk(0, 1, 1, 2'd3, 1,   2'd0, 0, 16'h0000, 2'd0, 1, 0);
        // flush at count 1 with an acceptable beat offered: beat is discarded
        vecs[17] = mk(0, 0, 1, 2'd0, 0,   2'd1, 1, 16'h1111, 2'd0, 1, 1);
        vecs[18] = mk(0, 1, 1, 2'd3, 0,   2'd0, 0, 16'h0000, 2'd0, 1, 0);
        vecs[19] = mk(0, 0, 0, 2'd0, 0,   2'd0, 0, 16'h0000, 2'd0, 1, 0);
        // simultaneous push/pop in ONE, then stall holds output stable
        vecs[20] = mk(0, 0, 1, 2'd0, 0,   2'd1, 1, 16'h1111, 2'd0, 1, 1);
        vecs[21] = mk(0, 0, 1, 2'd3, 1,   2'd1, 1, 16'h4444, 2'd3, 1, 1);
        vecs[22] = mk(0, 0, 0, 2'd0, 0,   2'd1, 1, 16'h4444, 2'd3, 1, 1);
        vecs[23] = mk(0, 0, 0, 2'd0, 1,   2'd0, 0, 16'h0000, 2'd0, 1, 0);
        // reset overrides flush and clears data registers
        vecs[24] = mk(0, 0, 1, 2'd2, 0,   2'd1, 1, 16'h3333, 2'd2, 1, 1);
        vecs[25] = mk(1, 1, 1, 2'd1, 0,   2'd0, 0, 16'h0000, 2'd0, 1, 1);
        vecs[26] = mk(0, 0, 0, 2'd0, 0,   2'd0, 0, 16'h0000, 2'd0, 1, 1);

        for (int i = 0; i < NV; i++) begin
            step_a(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].sel, vecs[i].ordy);
            chk($sformatf("v%0d count", i), 32'(a_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d out_valid", i), 32'(a_ov), 32'(vecs[i].ov));
            chk($sformatf("v%0d in_ready", i), 32'(a_ir), 32'(vecs[i].ir));
            chk($sformatf("v%0d err", i), 32'(a_err), 32'd0);
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d out_data", i), 32'(a_od), 32'(vecs[i].od));
                chk($sformatf("v%0d out_sel", i), 32'(a_os), 32'(vecs[i].os));
            end
        end

        // Scoreboard run: 10 beats under an irregular out_ready pattern.
        begin
            int pushed = 0;
            int popped = 0;
            logic [1:0] seq [10] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0};
            for (int c = 0; c < 60 && popped < 10; c++) begin
                @(negedge clk);
                a_rst  = 1'b0;
                a_fl   = 1'b0;
                a_iv   = (pushed < 10);
                a_sel  = (pushed < 10) ? seq[pushed] : 2'd0;
                a_ordy = ((c % 4) != 1) && ((c % 7) != 3);
                #1;
                if (a_ov && a_ordy) begin
                    if (exp_q.size() == 0) begin
                        chk("sb pop from empty model", 32'(a_od), 32'hffffffff);
                    end else begin
                        chk($sformatf("sb beat %0d", popped), 32'(a_od), 32'(exp_q.pop_front()));
                    end
                    popped++;
                end
                if (a_iv && a_ir) begin
                    exp_q.push_back(a_val(a_sel));
                    pushed++;
                end
            end
            @(negedge clk);
            a_iv = 1'b0;
            chk("sb beats delivered", 32'(popped), 32'd10);
            chk("sb model drained", 32'(exp_q.size()), 32'd0);
        end

        // Out-of-range select on the 3-input instance.
        step_b(1, 0, 1, 2'd3, 0);
        step_b(0, 0, 0, 2'd0, 0);
        chk("b reset err", 32'(b_err), 32'd0);
        chk("b reset count", 32'(b_cnt), 32'd0);
        step_b(0, 0, 1, 2'd1, 0);
        chk("b sel1 data", 32'(b_od), 32'h0000bbbb);
        step_b(0, 0, 1, 2'd3, 1);
        chk("b oor count", 32'(b_cnt), 32'd1);
        chk("b oor out_sel", 32'(b_os), 32'd3);
`ifdef SEL_SKID_MUX_RANGE_CHECK_EN
        chk("b oor data", 32'(b_od), 32'h0);
        chk("b oor err", 32'(b_err), 32'd1);
        step_b(0, 1, 0, 2'd0, 0);
        chk("b err after flush", 32'(b_err), 32'd1);
        chk("b count after flush", 32'(b_cnt), 32'd0);
        step_b(0, 0, 0, 2'd0, 0);
        chk("b err holds", 32'(b_err), 32'd1);
`else
        chk("b oor data", 32'(b_od), 32'h0000cccc);
        chk("b oor err", 32'(b_err), 32'd0);
        step_b(0, 1, 0, 2'd0, 0);
        chk("b err after flush", 32'(b_err), 32'd0);
        chk("b count after flush", 32'(b_cnt), 32'd0);
`endif
        step_b(1, 0, 0, 2'd0, 0);
        step_b(0, 0, 0, 2'd0, 0);
        chk("b err after reset", 32'(b_err), 32'd0);
        chk("b data after reset", 32'(b_od), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
